alu_muldiv: RTL and testbench

Iterative multiply/divide unit implementing the RISC-V M-extension operations next to the single-cycle alu. Generalises the combinational ALU with a parametrised data width, a multi-cycle datapath (shift-add multiplier, restoring divider) and valid/ready handshakes on input and output. One operation is in flight at a time. A kill input lets the pipeline abort it on flush.

---
 rtl/alu_muldiv.sv | 189 ++++++++++++++++++
 tb/tb_alu_muldiv.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_muldiv.sv
// alu_muldiv: iterative RISC-V M-extension multiply/divide unit.
// Shift-add multiplier and restoring divider on operand magnitudes, with a
// sign fix-up on the final iteration. One operation in flight, valid/ready
// on both sides, kill aborts the operation in flight.
// Optional feature: define MULDIV_EARLY_OUT_EN to finish zero-operand,
// divide-by-zero and signed-overflow cases one clock after acceptance.
module alu_muldiv #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned CNT_W = $clog2(XLEN) + 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [2:0]      alu_op,
   input  logic [XLEN-1:0] r1,
   input  logic [XLEN-1:0] r2,
   input  logic            kill,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic            busy
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t state, state_nxt;

   logic [2:0]      op_q;
   logic [XLEN-1:0] hi_q, lo_q, b_q;
   logic [CNT_W-1:0] cnt_q;
   logic            neg_res_q, neg_rem_q, dz_q;

   logic            is_div_c, sgn1_c, sgn2_c, neg1_c, neg2_c;
   logic [XLEN-1:0] mag1_c, mag2_c;
   logic            accept_c, last_c;
   logic            early_c;
   logic [XLEN-1:0] early_res_c;

   logic [XLEN:0]     sum_c, rem_sh_c, diff_c;
   logic              ge_c;
   logic [XLEN-1:0]   it_hi_c, it_lo_c;
   logic [2*XLEN-1:0] prod_c;
   logic [XLEN-1:0]   quo_c, rem_c, final_c;

   // Request-side decode: operand signedness, magnitudes and signs
   always_comb begin
      is_div_c = alu_op[2];
      sgn1_c   = is_div_c ? ~alu_op[0] : ((alu_op[1:0] == 2'b01) || (alu_op[1:0] == 2'b10));
      sgn2_c   = is_div_c ? ~alu_op[0] : (alu_op[1:0] == 2'b01);
      neg1_c   = sgn1_c & r1[XLEN-1];
      neg2_c   = sgn2_c & r2[XLEN-1];
      mag1_c   = neg1_c ? -r1 : r1;
      mag2_c   = neg2_c ? -r2 : r2;
      accept_c = (state == ST_IDLE) && in_valid && !kill;
      last_c   = (state == ST_CALC) && !kill && (cnt_q == CNT_W'(1));
   end

`ifdef MULDIV_EARLY_OUT_EN
   localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};
   logic div_zero_c, ovf_c;

   // Trivial cases whose result is known directly from the operands
   always_comb begin
      div_zero_c  = is_div_c && (r2 == '0);
      ovf_c       = is_div_c && !alu_op[0] && (r1 == MIN_VAL) && (r2 == '1);
      early_c     = (r1 == '0) || (r2 == '0) || ovf_c;
      early_res_c = '0;
      if (div_zero_c) begin
         early_res_c = alu_op[1] ? r1 : '1;
      end else if (ovf_c) begin
         early_res_c = alu_op[1] ? '0 : r1;
      end
   end
`else
   assign early_c     = 1'b0;
   assign early_res_c = '0;
`endif

   // One multiply (shift-add) or divide (restoring) step on the held state
   always_comb begin
      sum_c    = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
      rem_sh_c = {hi_q, lo_q[XLEN-1]};
      diff_c   = rem_sh_c - {1'b0, b_q};
      ge_c     = ~diff_c[XLEN];
      if (op_q[2]) begin
         it_hi_c = ge_c ? diff_c[XLEN-1:0] : rem_sh_c[XLEN-1:0];
         it_lo_c = {lo_q[XLEN-2:0], ge_c};
      end else begin
         it_hi_c = sum_c[XLEN:1];
         it_lo_c = {sum_c[0], lo_q[XLEN-1:1]};
      end
   end

   // Sign correction and result selection applied on the last step
   always_comb begin
      prod_c = neg_res_q ? -{it_hi_c, it_lo_c} : {it_hi_c, it_lo_c};
      quo_c  = dz_q ? '1 : (neg_res_q ? -it_lo_c : it_lo_c);
      rem_c  = neg_rem_q ? -it_hi_c : it_hi_c;
      if (op_q[2]) begin
         final_c = op_q[1] ? rem_c : quo_c;
      end else begin
         final_c = (op_q[1:0] == 2'b00) ? prod_c[XLEN-1:0] : prod_c[2*XLEN-1:XLEN];
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (accept_c) begin
               state_nxt = early_c ? ST_DONE : ST_CALC;
            end
         end
         ST_CALC: begin
            if (kill) begin
               state_nxt = ST_IDLE;
            end else if (cnt_q == CNT_W'(1)) begin
               state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            if (kill || out_ready) begin
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // State register and registered handshake/status outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         state     <= state_nxt;
         in_ready  <= (state_nxt == ST_IDLE);
         out_valid <= (state_nxt == ST_DONE);
         busy      <= (state_nxt != ST_IDLE);
      end
   end

   // Datapath: operand capture, iteration, result write
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_q      <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         b_q       <= '0;
         cnt_q     <= '0;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         dz_q      <= 1'b0;
         result    <= '0;
      end else if (accept_c) begin
         op_q      <= alu_op;
         hi_q      <= '0;
         lo_q      <= is_div_c ? mag1_c : mag2_c;
         b_q       <= is_div_c ? mag2_c : mag1_c;
         cnt_q     <= early_c ? '0 : CNT_W'(XLEN);
         neg_res_q <= neg1_c ^ neg2_c;
         neg_rem_q <= neg1_c;
         dz_q      <= (r2 == '0);
         if (early_c) begin
            result <= early_res_c;
         end
      end else if (state == ST_CALC) begin
         if (kill) begin
            cnt_q <= '0;
         end else begin
            hi_q  <= it_hi_c;
            lo_q  <= it_lo_c;
            cnt_q <= cnt_q - CNT_W'(1);
            if (last_c) begin
               result <= final_c;
            end
         end
      end
   end

endmodule

// File: tb/tb_alu_muldiv.sv
// Testbench for alu_muldiv: directed vectors with literal expectations plus a
// transaction-level reference model compared against the outputs every cycle.
module tb_alu_muldiv;

   localparam int unsigned XLEN = 32;
`ifdef MULDIV_EARLY_OUT_EN
   localparam bit EARLY = 1'b1;
`else
   localparam bit EARLY = 1'b0;
`endif

   localparam int P_IDLE = 0;
   localparam int P_CALC = 1;
   localparam int P_DONE = 2;

   logic            clk = 1'b0;
   logic            rst;
   logic            in_valid, in_ready, kill, out_valid, out_ready, busy;
   logic [2:0]      alu_op;
   logic [XLEN-1:0] r1, r2, result;

   int n_cmp  = 0;
   int n_fail = 0;

   int              m_phase;
   int              m_left;
   logic [XLEN-1:0] m_exp, m_result;

   always #5 clk = ~clk;

   alu_muldiv #(.XLEN(XLEN)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .alu_op    (alu_op),
      .r1        (r1),
      .r2        (r2),
      .kill      (kill),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .busy      (busy)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Architectural result of an M-extension op, from plain 64-bit arithmetic
   function automatic logic [31:0] ref_calc(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
      logic [63:0]        p;
      logic signed [31:0] sa, sb;
      logic [31:0]        res;
      sa = a;
      sb = b;
      p  = '0;
      case (op)
         3'd0: begin p = {32'b0, a} * {32'b0, b};                     res = p[31:0];  end
         3'd1: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b};         res = p[63:32]; end
         3'd2: begin p = {{32{a[31]}}, a} * {32'b0, b};               res = p[63:32]; end
         3'd3: begin p = {32'b0, a} * {32'b0, b};                     res = p[63:32]; end
         3'd4: begin
            if (b == 32'd0)                                   res = 32'hFFFF_FFFF;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) res = a;
            else                                              res = 32'(sa / sb);
         end
         3'd5: res = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
         3'd6: begin
            if (b == 32'd0)                                   res = a;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) res = 32'd0;
            else                                              res = 32'(sa % sb);
         end
         default: res = (b == 32'd0) ? a : a % b;
      endcase
      return res;
   endfunction

   function automatic bit is_early(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      bit ovf;
      ovf = op[2] && !op[0] && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      return EARLY && ((a == 32'd0) || (b == 32'd0) || ovf);
   endfunction

   // Transaction-level model: accepted op, remaining latency, visible result
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_phase  = P_IDLE;
         m_left   = 0;
         m_exp    = '0;
         m_result = '0;
      end else begin
         case (m_phase)
            P_IDLE: begin
               if (in_valid && !kill) begin
                  m_exp = ref_calc(alu_op, r1, r2);
                  if (is_early(alu_op, r1, r2)) begin
                     m_phase  = P_DONE;
                     m_result = m_exp;
                  end else begin
                     m_phase = P_CALC;
                     m_left  = XLEN;
                  end
               end
            end
            P_CALC: begin
               if (kill) begin
                  m_phase = P_IDLE;
               end else begin
                  m_left--;
                  if (m_left == 0) begin
                     m_phase  = P_DONE;
                     m_result = m_exp;
                  end
               end
            end
            default: begin
               if (kill || out_ready) m_phase = P_IDLE;
            end
         endcase
      end
   end

   // Every-cycle comparison against the model
   always @(negedge clk) begin
      if (rst === 1'b0) begin
         check("in_ready",  64'(in_ready),  64'(m_phase == P_IDLE));
         check("busy",      64'(busy),      64'(m_phase != P_IDLE));
         check("out_valid", 64'(out_valid), 64'(m_phase == P_DONE));
         check("result",    64'(result),    64'(m_result));
      end
   end

   task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int hold);
      int lat;
      int exp_lat;
      exp_lat = is_early(op, a, b) ? 1 : XLEN + 1;
      @(negedge clk);
      check({name, " in_ready"}, 64'(in_ready), 64'd1);
      in_valid = 1'b1;
      alu_op   = op;
      r1       = a;
      r2       = b;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      alu_op   = 3'($urandom);
      r1       = $urandom;
      r2       = $urandom;
      lat      = 1;
      while (!out_valid && lat < 200) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check({name, " latency"}, 64'(lat), 64'(exp_lat));
      check({name, " value"}, 64'(result), 64'(exp));
      repeat (hold) begin
         @(posedge clk);
         #1;
         check({name, " held value"}, 64'(result), 64'(exp));
         check({name, " held in_ready"}, 64'(in_ready), 64'd0);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check({name, " out_valid drop"}, 64'(out_valid), 64'd0);
      check({name, " back to idle"}, 64'(in_ready), 64'd1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int seen;
      rst       = 1'b1;
      in_valid  = 1'b0;
      kill      = 1'b0;
      out_ready = 1'b0;
      alu_op    = '0;
      r1        = '0;
      r2        = '0;
      repeat (2) @(negedge clk);
      #1;
      check("reset in_ready",  64'(in_ready),  64'd1);
      check("reset out_valid", 64'(out_valid), 64'd0);
      check("reset busy",      64'(busy),      64'd0);
      check("reset result",    64'(result),    64'd0);
      @(negedge clk);
      rst = 1'b0;

      run_op("MUL 7*-3",        3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 0);
      run_op("MULHU max*max",   3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 0);
      run_op("MULHSU -1*2",     3'd2, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, 0);
      run_op("MULH -1*-1",      3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000, 0);
      run_op("MULH min*min",    3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 0);
      run_op("DIV -20/3",       3'd4, 32'hFFFF_FFEC,  32'd3,         32'hFFFF_FFFA, 0);
      run_op("REM -20/3",       3'd6, 32'hFFFF_FFEC,  32'd3,         32'hFFFF_FFFE, 0);
      run_op("DIV 20/-3",       3'd4, 32'd20,         32'hFFFF_FFFD, 32'hFFFF_FFFA, 0);
      run_op("REM 20/-3",       3'd6, 32'd20,         32'hFFFF_FFFD, 32'd2,         0);
      run_op("DIVU 20/3",       3'd5, 32'd20,         32'd3,         32'd6,         0);
      run_op("REMU 20/3",       3'd7, 32'd20,         32'd3,         32'd2,         0);
      run_op("DIV 5/0",         3'd4, 32'd5,          32'd0,         32'hFFFF_FFFF, 0);
      run_op("DIV -5/0",        3'd4, 32'hFFFF_FFFB,  32'd0,         32'hFFFF_FFFF, 0);
      run_op("REM 5/0",         3'd6, 32'd5,          32'd0,         32'd5,         0);
      run_op("DIVU 5/0",        3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF, 0);
      run_op("REMU 7/0",        3'd7, 32'd7,          32'd0,         32'd7,         0);
      run_op("DIV ovf",         3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 0);
      run_op("REM ovf",         3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         0);
      run_op("MUL 0*x",         3'd0, 32'd0,          32'h1234_5678, 32'd0,         0);
      run_op("DIV 0/5",         3'd4, 32'd0,          32'd5,         32'd0,         0);
      run_op("MUL 3*5 bp",      3'd0, 32'd3,          32'd5,         32'd15,        5);
      run_op("DIVU after bp",   3'd5, 32'd1000,       32'd7,         32'd142,       0);

      // Kill partway through a DIVU: no result must ever appear
      @(negedge clk);
      in_valid = 1'b1;
      alu_op   = 3'd5;
      r1       = 32'd100;
      r2       = 32'd7;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (14) @(posedge clk);
      #1;
      kill = 1'b1;
      @(posedge clk);
      #1;
      kill = 1'b0;
      check("kill calc in_ready",  64'(in_ready),  64'd1);
      check("kill calc out_valid", 64'(out_valid), 64'd0);
      check("kill calc result",    64'(result),    64'd142);
      seen = 0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (out_valid) seen = 1;
      end
      check("kill calc no out_valid", 64'(seen), 64'd0);

      // kill together with in_valid in IDLE: nothing accepted
      @(negedge clk);
      in_valid = 1'b1;
      kill     = 1'b1;
      alu_op   = 3'd0;
      r1       = 32'd3;
      r2       = 32'd4;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      kill     = 1'b0;
      check("kill idle in_ready", 64'(in_ready), 64'd1);
      check("kill idle busy",     64'(busy),     64'd0);

      // Asynchronous reset mid-calculation
      @(negedge clk);
      in_valid = 1'b1;
      alu_op   = 3'd0;
      r1       = 32'd3;
      r2       = 32'd5;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (8) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("async rst in_ready",  64'(in_ready),  64'd1);
      check("async rst out_valid", 64'(out_valid), 64'd0);
      check("async rst busy",      64'(busy),      64'd0);
      check("async rst result",    64'(result),    64'd0);
      @(negedge clk);
      rst = 1'b0;

      run_op("MUL after rst",   3'd0, 32'd3,          32'd5,         32'd15,        0);

      repeat (3) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
